// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: buffers a host coefficient set into a shadow bank, resets and loads the
// FIR filter from it, then forwards host samples to the filter as start/x_in beats.
module fir_coeff_sequencer #(
  parameter int unsigned N  = 100,
  parameter int unsigned W  = 16,
  parameter int unsigned IW = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_last,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         fir_rst,
  output logic         load_coeff,
  output logic [W-1:0] coeff_out,
  output logic         start,
  output logic [W-1:0] x_out,
  output logic         loaded
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StClr   = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;
  localparam logic [1:0] StRun   = 2'd3;

  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IW:0]   fill_q, fill_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [W-1:0]  shadow_q [N];

  logic          fir_rst_q, fir_rst_d;
  logic          load_coeff_q, load_coeff_d;
  logic [W-1:0]  coeff_out_q, coeff_out_d;
  logic          start_q, start_d;
  logic [W-1:0]  x_out_q, x_out_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          s_ready_q, s_ready_d;
  logic          loaded_q, loaded_d;

  logic cfg_acc;
  logic s_acc;
  logic commit;

  assign cfg_acc = cfg_valid & cfg_ready_q;
  assign s_acc   = s_valid & s_ready_q;
  // The N-th beat commits on its own, so the write counter can never run past the bank.
  assign commit  = cfg_acc & (cfg_last | (wr_cnt_q == LastIdx));

  // Next-state logic for the control FSM, fill counter and load index.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    fill_d   = fill_q;
    rd_idx_d = rd_idx_q;
    if (cfg_acc) begin
      wr_cnt_d = wr_cnt_q + IW'(1);
    end
    if (commit) begin
      wr_cnt_d = '0;
      fill_d   = {1'b0, wr_cnt_q} + {{IW{1'b0}}, 1'b1};
    end
    case (state_q)
      StEmpty, StRun: begin
        if (commit) begin
          state_d = StClr;
        end
      end
      StClr: begin
        // A sample forwarded on the commit edge holds off the filter reset by one cycle.
        if (!start_q) begin
          state_d  = StLoad;
          rd_idx_d = '0;
        end
      end
      StLoad: begin
        if (rd_idx_q == LastIdx) begin
          state_d = StRun;
        end else begin
          rd_idx_d = rd_idx_q + IW'(1);
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Registered output values, derived from the next state so every output is a flop.
  always_comb begin
    load_coeff_d = (state_d == StLoad);
    coeff_out_d  = '0;
    if (load_coeff_d && ({1'b0, rd_idx_d} < fill_d)) begin
      coeff_out_d = shadow_q[rd_idx_d];
    end
    start_d     = s_acc;
    x_out_d     = s_acc ? s_data : x_out_q;
    fir_rst_d   = (state_d == StEmpty) || ((state_d == StClr) && !start_d);
    cfg_ready_d = (state_d == StEmpty) || (state_d == StRun);
    s_ready_d   = (state_d == StRun);
    loaded_d    = (state_d == StRun);
  end

  // Control state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StEmpty;
      wr_cnt_q     <= '0;
      fill_q       <= '0;
      rd_idx_q     <= '0;
      fir_rst_q    <= 1'b1;
      load_coeff_q <= 1'b0;
      coeff_out_q  <= '0;
      start_q      <= 1'b0;
      x_out_q      <= '0;
      cfg_ready_q  <= 1'b1;
      s_ready_q    <= 1'b0;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      fill_q       <= fill_d;
      rd_idx_q     <= rd_idx_d;
      fir_rst_q    <= fir_rst_d;
      load_coeff_q <= load_coeff_d;
      coeff_out_q  <= coeff_out_d;
      start_q      <= start_d;
      x_out_q      <= x_out_d;
      cfg_ready_q  <= cfg_ready_d;
      s_ready_q    <= s_ready_d;
      loaded_q     <= loaded_d;
    end
  end

  // Shadow bank write; no reset since stale entries are masked by the fill count.
  always_ff @(posedge clk) begin
    if (cfg_acc) begin
      shadow_q[wr_cnt_q] <= cfg_data;
    end
  end

  assign fir_rst    = fir_rst_q;
  assign load_coeff = load_coeff_q;
  assign coeff_out  = coeff_out_q;
  assign start      = start_q;
  assign x_out      = x_out_q;
  assign cfg_ready  = cfg_ready_q;
  assign s_ready    = s_ready_q;
  assign loaded     = loaded_q;

endmodule

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Front-end sequencer for the symmetric pipelined FIR filter. It buffers a coefficient set from a host valid/ready stream into a shadow bank, then drives the filter's `load_coeff`/`coeff_in` port and its active-high reset. After the load it forwards host samples as `start`/`x_in` beats. It sits between the host/config logic and the filter, and is the only block that drives the filter's control inputs.

## Interface
- `N`, 100: filter tap count; must equal the filter's `N`; 2..127.
- `W`, 16: coefficient and sample width (two's complement).
- `IW`, 7: index/counter width; 2^IW ≥ N.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (rst=0 resets).
- `cfg_valid`  in  1  host coefficient beat valid.
- `cfg_ready`  out  1  coefficient beat accepted when valid&ready at an edge.
- `cfg_data`  in  W  coefficient value, tap order 0 first.
- `cfg_last`  in  1  final coefficient of the set; commits the set.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample accepted when valid&ready.
- `s_data`  in  W  sample value.
- `fir_rst`  out  1  active-high reset to the filter.
- `load_coeff`  out  1  to filter `load_coeff`.
- `coeff_out`  out  W  to filter `coeff_in`.
- `start`  out  1  to filter `start`.
- `x_out`  out  W  to filter `x_in`.
- `loaded`  out  1  a coefficient set is resident in the filter.

## Operation
- States: EMPTY, CLR, LOAD, RUN. Reset state is EMPTY.
- Shadow bank: N×W registers, not reset. `wr_cnt` (IW bits) resets to 0.
- Fill: `cfg_ready` = 1 in EMPTY and RUN, 0 in CLR and LOAD. Each accepted beat writes `shadow[wr_cnt]` and increments `wr_cnt`.
- Commit: an accepted beat with `cfg_last`=1, or the accepted beat with `wr_cnt` = N-1 (auto-commit, `cfg_last` ignored). Commit latches `fill = wr_cnt+1`, clears `wr_cnt`, and moves to CLR. Overflow past N is therefore impossible.
- EMPTY: `fir_rst`=1, `s_ready`=0, `loaded`=0.
- CLR: exactly 1 cycle with `fir_rst`=1. This zeroes the filter's `coeff_index`, delay line and pipeline. Next state is LOAD.
- LOAD: exactly N cycles, `rd_idx` 0..N-1.
  - `load_coeff`=1.
  - `coeff_out = shadow[rd_idx]` if `rd_idx < fill`, else 0 (zero-padding of short sets).
  - `fir_rst`=0, `start`=0.
  - After `rd_idx` = N-1, go to RUN and set `loaded`=1.
- RUN:
  - `s_ready`=1.
  - Each accepted sample produces one cycle of `start`=1 with `x_out=s_data`. `x_out` holds its value when `start`=0.
- `load_coeff` and `start` are never 1 in the same cycle. `fir_rst` is never 1 while either of them is 1.
- Reload from RUN: a commit in RUN goes to CLR. `loaded` drops to 0 in CLR and LOAD. A sample accepted on the same edge as the commit is still forwarded. `s_ready` is 0 from the next cycle until RUN resumes.
- Reset mid-operation (any state): immediate return to EMPTY with all outputs at reset values. A partial set is discarded (`wr_cnt`=0).

## Timing
- All outputs are registered. They change only on `clk` rising edges, or asynchronously to reset values on rst=0.
- Reset values: `fir_rst`=1, `load_coeff`=0, `coeff_out`=0, `start`=0, `x_out`=0, `cfg_ready`=1, `s_ready`=0, `loaded`=0.
- Commit accepted at edge T:
  - `fir_rst`=1 during cycle T..T+1.
  - `load_coeff`=1 for cycles T+1..T+N, with tap k presented in cycle T+1+k.
  - `loaded`=1 and `s_ready`=1 from edge T+N+1.
- Sample path latency: sample accepted at edge T appears as `start`=1 / `x_out` in the following cycle. Throughput is 1 sample per clock.
- Handshakes:
  - Data and `last` must hold while valid=1 and ready=0. Valid may not depend on ready.
  - While `cfg_ready`=0 (CLR/LOAD), host config beats stall; no beat is dropped.

## Test plan
- Reset then full set: push N beats 1..N, with no `cfg_last` → `fir_rst` pulse, 100 load beats with `coeff_out`=1..100, then `loaded`=1 and `s_ready`=1 at commit edge + N+1.
- Short set: 3 beats (5, -2, 7) with `cfg_last` on the third → `coeff_out` = 5, -2, 7, then 97 zeros. `load_coeff` high for exactly 100 cycles.
- Sample stream: after load, s_data = 1, 2, 3 with `s_valid` toggling 1,0,1,1 → `start` = 1,0,1,1 one cycle later, `x_out` = 1, 1(held), 2, 3.
- Reload during RUN: commit on the same edge as sample 0x7FFF is accepted → `start`=1 with `x_out`=0x7FFF. Next cycle `fir_rst`=1, then 100 load cycles with `s_ready`=0 and `cfg_ready`=0, then RUN resumes.
- Reset mid-LOAD: assert rst=0 at `rd_idx`=40 → all outputs return to reset values immediately. A fresh 2-beat set then loads cleanly from index 0.
- Invariant check (all tests): `load_coeff`&`start`, `fir_rst`&`load_coeff` and `fir_rst`&`start` are never 1 together.
